// File: rtl/mio_int_ctrl_if.sv
// mio_int_ctrl_if: interrupt sources, CPU Ireq/Iack handshake and MIO register port of mio_int_ctrl.
// slave = controller side; master = CPU / MIO bus / peripheral side.
interface mio_int_ctrl_if #(
   parameter int N_CH = 8,
   parameter int ID_W = 3
);
   logic [N_CH-1:0] irq_in;
   logic            Iack;
   logic [1:0]      reg_sel;
   logic            reg_we;
   logic [31:0]     reg_wdata;
   logic [31:0]     reg_rdata;
   logic            Ireq;
   logic [ID_W-1:0] int_id;

   modport slave (
      input  irq_in, Iack, reg_sel, reg_we, reg_wdata,
      output reg_rdata, Ireq, int_id
   );

   modport master (
      output irq_in, Iack, reg_sel, reg_we, reg_wdata,
      input  reg_rdata, Ireq, int_id
   );
endinterface

// File: rtl/mio_int_ctrl.sv
// mio_int_ctrl: N_CH-source interrupt controller, fixed priority (ch0 highest), REQ/SERV/EOI handshake to the CPU.
// Source-to-Ireq latency 2 cycles (+2 with INTC_SYNC_EN synchroniser); no backpressure, register writes always accepted.
module mio_int_ctrl #(
   parameter int N_CH = 8,
   parameter int ID_W = 3
) (
   input  logic          clk,
   input  logic          reset,
   mio_int_ctrl_if.slave i_bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SERV = 2'd2
   } state_t;

   localparam logic [1:0] SEL_PEND = 2'd0;
   localparam logic [1:0] SEL_MASK = 2'd1;
   localparam logic [1:0] SEL_MODE = 2'd2;
   localparam logic [1:0] SEL_CTRL = 2'd3;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            r_ireq;
   logic            w_ireq_nxt;
   logic [ID_W-1:0] r_int_id;
   logic [ID_W-1:0] w_id_nxt;
   logic [ID_W-1:0] w_winner;

   logic [N_CH-1:0] r_pend;
   logic [N_CH-1:0] r_mask;
   logic [N_CH-1:0] r_mode;
   logic [N_CH-1:0] r_prev;
   logic            r_iack_q;

   logic [N_CH-1:0] w_src;
   logic [N_CH-1:0] w_rise;
   logic [N_CH-1:0] w_ack_clr;
   logic [N_CH-1:0] w_w1c;
   logic [N_CH-1:0] w_pend_nxt;
   logic [N_CH-1:0] w_cand;
   logic [N_CH-1:0] w_wdata;
   logic            w_any;
   logic            w_iack_pulse;
   logic            w_ack;
   logic            w_eoi;
   logic            w_wr_pend;
   logic            w_wr_mask;
   logic            w_wr_mode;
   logic [31:0]     w_rdata;
   logic            w_unused_wdata;

   // Write data above the channel count is ignored by design.
   assign w_wdata        = i_bus.reg_wdata[N_CH-1:0];
   assign w_unused_wdata = ^i_bus.reg_wdata;

`ifdef INTC_SYNC_EN
   logic [N_CH-1:0] r_sync1;
   logic [N_CH-1:0] r_sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= i_bus.irq_in;
         r_sync2 <= r_sync1;
      end
   end

   assign w_src = r_sync2;
`else
   assign w_src = i_bus.irq_in;
`endif

   assign w_rise       = w_src & ~r_prev;
   assign w_iack_pulse = i_bus.Iack & ~r_iack_q;
   assign w_ack        = (r_state == ST_REQ) && w_iack_pulse;
   assign w_eoi        = i_bus.reg_we && (i_bus.reg_sel == SEL_CTRL) && (r_state == ST_SERV);
   assign w_wr_pend    = i_bus.reg_we && (i_bus.reg_sel == SEL_PEND);
   assign w_wr_mask    = i_bus.reg_we && (i_bus.reg_sel == SEL_MASK);
   assign w_wr_mode    = i_bus.reg_we && (i_bus.reg_sel == SEL_MODE);
   assign w_w1c        = w_wr_pend ? w_wdata : '0;

   always_comb begin
      w_ack_clr = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_ack_clr[i] = w_ack && (r_int_id == ID_W'(i));
      end
   end

   // Edge channels: clears first, then a same-cycle rise re-sets. Level channels track the source.
   assign w_pend_nxt = (r_mode & ((r_pend & ~(w_w1c | w_ack_clr)) | w_rise))
                     | (~r_mode & w_src);

   assign w_cand = r_pend & r_mask;
   assign w_any  = |w_cand;

   always_comb begin
      w_winner = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (w_cand[i]) begin
            w_winner = ID_W'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pend   <= '0;
         r_mask   <= '0;
         r_mode   <= '1;
         r_prev   <= '0;
         r_iack_q <= 1'b0;
      end else begin
         r_pend   <= w_pend_nxt;
         r_prev   <= w_src;
         r_iack_q <= i_bus.Iack;
         if (w_wr_mask) begin
            r_mask <= w_wdata;
         end
         if (w_wr_mode) begin
            r_mode <= w_wdata;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_ireq   <= 1'b0;
         r_int_id <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_ireq   <= w_ireq_nxt;
         r_int_id <= w_id_nxt;
      end
   end

   // int_id is frozen through REQ/SERV and returns to 0 on EOI so an idle CTRL reads 0.
   always_comb begin
      w_state_nxt = r_state;
      w_ireq_nxt  = r_ireq;
      w_id_nxt    = r_int_id;
      unique case (r_state)
         ST_IDLE: begin
            if (w_any) begin
               w_state_nxt = ST_REQ;
               w_ireq_nxt  = 1'b1;
               w_id_nxt    = w_winner;
            end
         end
         ST_REQ: begin
            if (w_ack) begin
               w_state_nxt = ST_SERV;
               w_ireq_nxt  = 1'b0;
            end
         end
         ST_SERV: begin
            if (w_eoi) begin
               w_state_nxt = ST_IDLE;
               w_id_nxt    = '0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_ireq_nxt  = 1'b0;
            w_id_nxt    = '0;
         end
      endcase
   end

   always_comb begin
      w_rdata = '0;
      unique case (i_bus.reg_sel)
         SEL_PEND: w_rdata[N_CH-1:0] = r_pend;
         SEL_MASK: w_rdata[N_CH-1:0] = r_mask;
         SEL_MODE: w_rdata[N_CH-1:0] = r_mode;
         SEL_CTRL: begin
            w_rdata[31]        = (r_state == ST_SERV);
            w_rdata[30:29]     = r_state;
            w_rdata[ID_W-1:0]  = r_int_id;
         end
         default: w_rdata = '0;
      endcase
   end

   assign i_bus.reg_rdata = w_rdata;
   assign i_bus.Ireq      = r_ireq;
   assign i_bus.int_id    = r_int_id;

endmodule
